// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV row accumulator: default widths,
// FSM state encoding and the result record carried through the FIFO.
package spmv_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_ROW_W      = 10;
  localparam int DEF_ACC_W      = 72;
  localparam int DEF_FIFO_DEPTH = 16;

  // Row-accumulator FSM states.
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;  // no row open
  localparam state_t S_OPEN  = 2'd1;  // a row is accumulating
  localparam state_t S_FLUSH = 2'd2;  // final row of a matrix is being pushed

  // One finished row as stored in the result FIFO (row in the upper bits).
  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_ACC_W-1:0] sum;
  } result_t;

endpackage

// File: rtl/spmv_result_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally from the storage registers, so an entry written at an
// edge is visible right after that edge. A push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module spmv_result_fifo #(
  parameter int WIDTH = 82,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  // Empty FIFO shows zeros so stale entries never leak onto the outputs.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of 2).
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/spmv_row_accumulator.sv
// Sums the product beats of each matrix row and queues one (row, sum)
// result per row. Upstream cannot be stalled, so a push into a full FIFO
// is dropped and recorded in the sticky overflow flag.
//
// Output handshake: a result transfers on every clk edge where
// out_valid && out_ready; while out_valid is high and out_ready is low,
// out_row/out_sum hold steady. out_valid never depends on out_ready.
module spmv_row_accumulator
  import spmv_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_op1,
  input  logic [DATA_W-1:0]           in_op2,
  input  logic [ROW_W-1:0]            in_row,
  input  logic                        in_zeros,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_W-1:0]            out_row,
  output logic [ACC_W-1:0]            out_sum,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        done,
  output logic                        overflow,
  output logic                        order_err,
  output logic [1:0]                  dbg_state
);

  state_t             state;
  logic [ROW_W-1:0]   cur_row;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   beat_sum;
  logic [ACC_W-1:0]   beat_val;
  logic               row_change;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  assign beat_sum = {{(ACC_W-DATA_W){in_op1[DATA_W-1]}}, in_op1}
                  + {{(ACC_W-DATA_W){in_op2[DATA_W-1]}}, in_op2};
  assign beat_val = in_zeros ? '0 : beat_sum;

  // A beat for a different row closes the open one; FLUSH closes the last row.
  assign row_change = (state == S_OPEN) && in_valid && (in_row != cur_row);
  assign push       = row_change || (state == S_FLUSH);
  assign pop        = out_valid && out_ready;
  assign done       = (state == S_FLUSH);
  assign out_valid  = !fifo_empty;
  assign dbg_state  = state;

  // Row FSM, accumulator and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cur_row   <= '0;
      acc       <= '0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (push && fifo_full && !pop)            overflow  <= 1'b1;
      if (row_change && (in_row < cur_row))     order_err <= 1'b1;
      case (state)
        S_OPEN: begin
          if (in_valid) begin
            if (in_row == cur_row) begin
              acc <= acc + beat_val;
            end else begin
              cur_row <= in_row;
              acc     <= beat_val;
            end
            state <= in_last ? S_FLUSH : S_OPEN;
          end
        end
        default: begin
          // IDLE and FLUSH both open a fresh row on a new beat.
          if (in_valid) begin
            cur_row <= in_row;
            acc     <= beat_val;
            state   <= in_last ? S_FLUSH : S_OPEN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  spmv_result_fifo #(
    .WIDTH (ROW_W + ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({cur_row, acc}),
    .pop       (pop),
    .pop_data  ({out_row, out_sum}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
